pipeline_ctrl: RTL and testbench

Pipeline control sequencer for the MIPS core: the consumer of the load-use hazard detector's stall requests and of the debug unit's run/step commands. It turns these into per-stage register enables, the IF/ID flush and the ID/EX bubble select. It tracks the run state (idle, continuous run, single-step, halted) and keeps cycle and stall counters for the debug unit to read. It sits between the hazard detector, the branch logic in ID, the debug unit and the five pipeline registers.

---
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl : run-state sequencer driving MIPS pipeline enables, flush,
// bubble select, and debug cycle/stall counters.
// Optional stall counter enabled by macro PIPELINE_CTRL_STALL_CNT_EN.
// Revision: 1.0
// ============================================================================
module pipeline_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_hazard_pc_write,
    input  logic                   i_hazard_if_id_write,
    input  logic                   i_hazard_mux_zero,
    input  logic                   i_branch_taken,
    input  logic                   i_halt_wb,
    input  logic                   i_dbg_start,
    input  logic                   i_dbg_mode,
    input  logic                   i_dbg_step,
    output logic                   o_pc_en,
    output logic                   o_if_id_en,
    output logic                   o_if_id_flush,
    output logic                   o_id_ex_en,
    output logic                   o_ex_mem_en,
    output logic                   o_mem_wb_en,
    output logic                   o_id_ex_bubble,
    output logic                   o_halted,
    output logic                   o_step_done,
    output logic [STALL_CNT_W-1:0] o_cycle_count,
    output logic [STALL_CNT_W-1:0] o_stall_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STEP_WAIT = 3'd2,
        S_STEP_EXEC = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    state_t state;
    state_t next_state;
    logic   active;

    assign active = (state == S_RUN) || (state == S_STEP_EXEC);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            o_halted    <= 1'b0;
            o_step_done <= 1'b0;
        end else begin
            state       <= next_state;
            o_halted    <= (next_state == S_HALTED);
            o_step_done <= (state == S_STEP_EXEC);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (i_dbg_start) begin
                    next_state = i_dbg_mode ? S_STEP_WAIT : S_RUN;
                end
            end
            S_RUN: begin
                if (i_halt_wb) begin
                    next_state = S_HALTED;
                end
            end
            S_STEP_WAIT: begin
                if (i_dbg_step) begin
                    next_state = S_STEP_EXEC;
                end
            end
            S_STEP_EXEC: begin
                next_state = i_halt_wb ? S_HALTED : S_STEP_WAIT;
            end
            S_HALTED: begin
                next_state = S_HALTED;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // A held IF/ID suppresses the flush; the branch re-resolves next cycle.
    always_comb begin
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b0;
        o_ex_mem_en    = 1'b0;
        o_mem_wb_en    = 1'b0;
        o_id_ex_bubble = 1'b0;
        if (active) begin
            o_pc_en        = ~i_hazard_pc_write;
            o_if_id_en     = ~i_hazard_if_id_write;
            o_if_id_flush  = i_branch_taken & ~i_hazard_if_id_write;
            o_id_ex_en     = 1'b1;
            o_ex_mem_en    = 1'b1;
            o_mem_wb_en    = 1'b1;
            o_id_ex_bubble = i_hazard_mux_zero;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_cycle_count <= '0;
        end else if (active && (o_cycle_count != CNT_MAX)) begin
            o_cycle_count <= o_cycle_count + 1'b1;
        end
    end

`ifdef PIPELINE_CTRL_STALL_CNT_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_stall_count <= '0;
        end else if (active && i_hazard_pc_write && (o_stall_count != CNT_MAX)) begin
            o_stall_count <= o_stall_count + 1'b1;
        end
    end
`else
    assign o_stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_ctrl : directed self-checking bench for pipeline_ctrl, with a
// 4-bit counter instance sharing stimulus to exercise saturation.
// Revision: 1.0
// ============================================================================
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hz_pc = 1'b0, hz_ifid = 1'b0, hz_mz = 1'b0, br = 1'b0, halt = 1'b0;
    logic start = 1'b0, mode = 1'b0, step = 1'b0;

    logic pc_en, if_id_en, if_id_flush, id_ex_en, ex_mem_en, mem_wb_en, bubble;
    logic halted, step_done;
    logic [15:0] cyc, stl;
    logic pc_en4, if_id_en4, if_id_flush4, id_ex_en4, ex_mem_en4, mem_wb_en4, bubble4;
    logic halted4, step_done4;
    logic [3:0] cyc4, stl4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.STALL_CNT_W(16)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_hazard_pc_write(hz_pc), .i_hazard_if_id_write(hz_ifid),
        .i_hazard_mux_zero(hz_mz), .i_branch_taken(br), .i_halt_wb(halt),
        .i_dbg_start(start), .i_dbg_mode(mode), .i_dbg_step(step),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
        .o_id_ex_en(id_ex_en), .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
        .o_id_ex_bubble(bubble), .o_halted(halted), .o_step_done(step_done),
        .o_cycle_count(cyc), .o_stall_count(stl)
    );

    pipeline_ctrl #(.STALL_CNT_W(4)) dut4 (
        .i_clock(clk), .i_reset(rst),
        .i_hazard_pc_write(hz_pc), .i_hazard_if_id_write(hz_ifid),
        .i_hazard_mux_zero(hz_mz), .i_branch_taken(br), .i_halt_wb(halt),
        .i_dbg_start(start), .i_dbg_mode(mode), .i_dbg_step(step),
        .o_pc_en(pc_en4), .o_if_id_en(if_id_en4), .o_if_id_flush(if_id_flush4),
        .o_id_ex_en(id_ex_en4), .o_ex_mem_en(ex_mem_en4), .o_mem_wb_en(mem_wb_en4),
        .o_id_ex_bubble(bubble4), .o_halted(halted4), .o_step_done(step_done4),
        .o_cycle_count(cyc4), .o_stall_count(stl4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack the seven combinational outputs: pc,ifid,flush,idex,exmem,memwb,bubble.
    function automatic logic [31:0] ens();
        return {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en, ex_mem_en, mem_wb_en, bubble};
    endfunction

    initial begin
        // Reset state
        tick();
        chk("reset_outputs", ens(), 32'h00);
        chk("reset_halted", {31'd0, halted}, 0);
        chk("reset_step_done", {31'd0, step_done}, 0);
        chk("reset_cycle", {16'd0, cyc}, 0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", ens(), 32'h00);

        // Continuous run, 10 clean cycles
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        #1 chk("run_enables", ens(), 32'b1101110);
        for (int i = 0; i < 10; i++) tick();
        chk("run10_cycle", {16'd0, cyc}, 10);
        chk("run10_stall", {16'd0, stl}, 0);

        // Full hazard with branch: hazard wins over flush
        hz_pc = 1'b1; hz_ifid = 1'b1; hz_mz = 1'b1; br = 1'b1;
        #1 chk("hazard_outputs", ens(), 32'b0001111);
        tick();
        #1 chk("hazard_outputs_2", ens(), 32'b0001111);
        tick();
        hz_pc = 1'b0; hz_ifid = 1'b0; hz_mz = 1'b0;
        #1 chk("branch_flush", ens(), 32'b1111110);
        chk("hazard_stall", {16'd0, stl}, STALL_EN ? 32'd2 : 32'd0);
        chk("hazard_cycle", {16'd0, cyc}, 12);
        tick();
        br = 1'b0;
        chk("cycle_13", {16'd0, cyc}, 13);

        // 20 hazard cycles: 4-bit instance saturates
        hz_pc = 1'b1; hz_ifid = 1'b1; hz_mz = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        hz_pc = 1'b0; hz_ifid = 1'b0; hz_mz = 1'b0;
        chk("sat_cycle4", {28'd0, cyc4}, 15);
        chk("sat_stall4", {28'd0, stl4}, STALL_EN ? 32'd15 : 32'd0);
        chk("cycle_33", {16'd0, cyc}, 33);
        chk("stall_22", {16'd0, stl}, STALL_EN ? 32'd22 : 32'd0);

        // Halt: the halt cycle is still active
        halt = 1'b1;
        #1 chk("halt_cycle_active", ens(), 32'b1101110);
        tick();
        halt = 1'b0;
        chk("halted_set", {31'd0, halted}, 1);
        chk("halted_outputs", ens(), 32'h00);
        chk("halt_cycle_count", {16'd0, cyc}, 34);
        start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        tick();
        chk("halted_sticky", {31'd0, halted}, 1);
        chk("halted_ignore_cmd", ens(), 32'h00);
        chk("halted_step_done", {31'd0, step_done}, 0);
        chk("halted_cycle_hold", {16'd0, cyc}, 34);

        // Reset, then step mode with three spaced steps
        rst = 1'b1;
        #1 chk("reset_async_cycle", {16'd0, cyc}, 0);
        chk("reset_async_halted", {31'd0, halted}, 0);
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0;
        #1 chk("step_wait_idle", ens(), 32'h00);
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            #1 chk($sformatf("step%0d_window", s), ens(), 32'b1101110);
            chk($sformatf("step%0d_no_early_done", s), {31'd0, step_done}, 0);
            tick();
            chk($sformatf("step%0d_done", s), {31'd0, step_done}, 1);
            chk($sformatf("step%0d_closed", s), ens(), 32'h00);
            tick();
            chk($sformatf("step%0d_done_1cyc", s), {31'd0, step_done}, 0);
            tick();
            tick();
        end
        chk("step_cycle_count", {16'd0, cyc}, 3);

        // Reset during STEP_EXEC aborts the step
        step = 1'b1;
        tick();
        step = 1'b0;
        #1 chk("abort_window", ens(), 32'b1101110);
        rst = 1'b1;
        #1 chk("abort_outputs", ens(), 32'h00);
        chk("abort_cycle", {16'd0, cyc}, 0);
        tick();
        chk("abort_no_done", {31'd0, step_done}, 0);
        rst = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        #1 chk("abort_idle", ens(), 32'h00);
        chk("abort_no_done_2", {31'd0, step_done}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
